// File: rtl/div_ratio_meter_if.sv
// Measurement bus of div_ratio_meter: the divided clock going in, the
// period / high-time / ratio / lock / timeout results coming out.
interface div_ratio_meter_if #(
  parameter int CNT_W = 8
);
  logic             iDivIN;
  logic [CNT_W-1:0] oPeriod;
  logic [CNT_W-1:0] oHigh;
  logic             oValid;
  logic [2:0]       oRatio;
  logic             oLocked;
  logic             oTimeout;

  modport master (
    output iDivIN,
    input  oPeriod, oHigh, oValid, oRatio, oLocked, oTimeout
  );

  modport slave (
    input  iDivIN,
    output oPeriod, oHigh, oValid, oRatio, oLocked, oTimeout
  );
endinterface

// File: rtl/div_ratio_meter.sv
// Measures a divided clock in iClkIN cycles: period, high time, a 2/4/8/16
// division code, lock on a stable period and loss-of-clock timeout.
module div_ratio_meter #(
  parameter int CNT_W  = 8,
  parameter int LOCK_N = 4,
  parameter int TOL    = 0
) (
  input  logic              iClkIN,
  input  logic              iRst,
  div_ratio_meter_if.slave  bus
);
  localparam logic [CNT_W-1:0] MAX_CNT = '1;
  localparam logic [3:0]       LOCK_V  = 4'(LOCK_N);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state_q, state_d;
  logic             s1, s2, s3, rise;
  logic [CNT_W-1:0] cnt, hcnt;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
  logic [2:0]       ratio_q, ratio_d;
  logic             valid_q, valid_d, locked_q, locked_d, tmo_q, tmo_d;
  logic             primed_q, primed_d;
  logic [3:0]       mcnt_q, mcnt_d, mcnt_inc;
  logic [CNT_W:0]   diff;
  logic             match;

  function automatic logic [2:0] ratio_of(input logic [CNT_W-1:0] p);
    case (int'(p))
      2:       ratio_of = 3'd1;
      4:       ratio_of = 3'd2;
      8:       ratio_of = 3'd3;
      16:      ratio_of = 3'd4;
      default: ratio_of = 3'd0;
    endcase
  endfunction

  // iDivIN is asynchronous: two flops to settle it, a third for edge history
  always_ff @(posedge iClkIN or posedge iRst) begin
    if (iRst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.iDivIN;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  always_ff @(posedge iClkIN or posedge iRst) begin
    if (iRst) begin
      cnt  <= '0;
      hcnt <= '0;
    end else if (rise) begin
      cnt  <= CNT_W'(1);
      hcnt <= CNT_W'(1);
    end else begin
      if (cnt != MAX_CNT)        cnt  <= cnt + 1'b1;
      if (s2 && hcnt != MAX_CNT) hcnt <= hcnt + 1'b1;
    end
  end

  // The first measurement after IDLE has no reference period, so it can
  // never match regardless of TOL.
  always_comb begin
    diff = (cnt >= period_q) ? ({1'b0, cnt} - {1'b0, period_q})
                             : ({1'b0, period_q} - {1'b0, cnt});
    match    = primed_q && (int'(diff) <= TOL);
    mcnt_inc = (mcnt_q == LOCK_V) ? mcnt_q : mcnt_q + 4'd1;
  end

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    high_d   = high_q;
    ratio_d  = ratio_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    tmo_d    = tmo_q;
    primed_d = primed_q;
    mcnt_d   = mcnt_q;
    case (state_q)
      IDLE: begin
        if (rise) state_d = MEASURE;
      end
      MEASURE: begin
        if (rise) begin
          period_d = cnt;
          high_d   = hcnt;
          ratio_d  = ratio_of(cnt);
          valid_d  = 1'b1;
          tmo_d    = 1'b0;
          primed_d = 1'b1;
          if (match) begin
            mcnt_d = mcnt_inc;
            if (mcnt_inc == LOCK_V) locked_d = 1'b1;
          end else begin
            mcnt_d   = 4'd0;
            locked_d = 1'b0;
          end
        end else if (cnt == MAX_CNT) begin
          state_d  = IDLE;
          tmo_d    = 1'b1;
          locked_d = 1'b0;
          mcnt_d   = 4'd0;
          period_d = '0;
          high_d   = '0;
          ratio_d  = 3'd0;
          primed_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClkIN or posedge iRst) begin
    if (iRst) begin
      state_q  <= IDLE;
      period_q <= '0;
      high_q   <= '0;
      ratio_q  <= 3'd0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      tmo_q    <= 1'b0;
      primed_q <= 1'b0;
      mcnt_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      high_q   <= high_d;
      ratio_q  <= ratio_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      tmo_q    <= tmo_d;
      primed_q <= primed_d;
      mcnt_q   <= mcnt_d;
    end
  end

  assign bus.oPeriod  = period_q;
  assign bus.oHigh    = high_q;
  assign bus.oRatio   = ratio_q;
  assign bus.oValid   = valid_q;
  assign bus.oLocked  = locked_q;
  assign bus.oTimeout = tmo_q;
endmodule

// File: tb/tb_div_ratio_meter.sv
// Directed bench for div_ratio_meter: a TOL=0 and a TOL=1 instance watch the
// same generated divided clock.
module tb_div_ratio_meter;
  logic iClkIN = 1'b0;
  logic iRst   = 1'b1;
  logic div    = 1'b0;
  int   checks = 0;
  int   failures = 0;

  int cur_p = 2, cur_h = 1, req_p = 2, req_p2 = 2, req_h = 1;
  int ph = 1 << 20;
  bit sel = 1'b0, gen_en = 1'b0, gen_lvl = 1'b0;

  div_ratio_meter_if #(.CNT_W(8)) b0();
  div_ratio_meter_if #(.CNT_W(8)) b1();
  assign b0.iDivIN = div;
  assign b1.iDivIN = div;

  div_ratio_meter #(.CNT_W(8), .LOCK_N(4), .TOL(0)) dut (
    .iClkIN(iClkIN), .iRst(iRst), .bus(b0.slave));
  div_ratio_meter #(.CNT_W(8), .LOCK_N(4), .TOL(1)) dut_t (
    .iClkIN(iClkIN), .iRst(iRst), .bus(b1.slave));

  always #5 iClkIN = ~iClkIN;

  // Divided-clock source; new period/high settings take effect at a period
  // boundary, and req_p/req_p2 alternate period by period.
  initial forever begin
    @(posedge iClkIN); #1;
    if (gen_en) begin
      if (ph + 1 >= cur_p) begin
        ph = 0; sel = ~sel;
        cur_p = sel ? req_p2 : req_p;
        cur_h = req_h;
      end else ph++;
      div = (ph < cur_h);
    end else begin
      ph  = 1 << 20;
      div = gen_lvl;
    end
  end

  function automatic logic [20:0] tup(input int w);
    if (w != 0) return {b1.oPeriod, b1.oHigh, b1.oRatio, b1.oLocked, b1.oTimeout};
    return {b0.oPeriod, b0.oHigh, b0.oRatio, b0.oLocked, b0.oTimeout};
  endfunction

  task automatic wait_valid(input int w, output bit ok);
    int n = 0;
    do begin @(negedge iClkIN); n++; end
    while (!((w != 0) ? b1.oValid : b0.oValid) && n < 1000);
    ok = (w != 0) ? b1.oValid : b0.oValid;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL wait_valid dut%0d: no oValid within %0d cycles", w, n);
    end
  endtask

  task automatic set_gen(input int p, input int p2, input int h);
    req_p = p; req_p2 = p2; req_h = h;
  endtask

  task automatic test_reset;
    iRst = 1'b1;
    repeat (3) @(negedge iClkIN);
    checks++;
    if ({tup(0), b0.oValid} !== 22'd0) begin
      failures++; $display("FAIL reset_state: got %h want 0", {tup(0), b0.oValid});
    end
    iRst = 1'b0;
  endtask

  task automatic test_div2;
    bit ok;
    logic [20:0] exp;
    set_gen(2, 2, 1); gen_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      wait_valid(0, ok);
      exp = {8'd2, 8'd1, 3'd1, (k >= 5), 1'b0};
      checks++;
      if (tup(0) !== exp) begin
        failures++; $display("FAIL div2_meas%0d: got %h want %h", k, tup(0), exp);
      end
    end
  endtask

  task automatic test_sweep;
    bit ok;
    int tries;
    logic [7:0] old = 8'd2, p, h;
    logic [2:0] r;
    logic [20:0] exp;
    for (int i = 0; i < 3; i++) begin
      p = 8'(4 << i); h = p >> 1; r = 3'(i + 2);
      set_gen(int'(p), int'(p), int'(h));
      tries = 0;
      do begin wait_valid(0, ok); tries++; end
      while (ok && b0.oPeriod == old && tries < 20);
      exp = {p, h, r, 1'b0, 1'b0};
      checks++;
      if (tup(0) !== exp) begin
        failures++; $display("FAIL sweep%0d_first: got %h want %h", int'(p), tup(0), exp);
      end
      for (int k = 1; k <= 4; k++) begin
        wait_valid(0, ok);
        exp = {p, h, r, (k == 4), 1'b0};
        checks++;
        if (tup(0) !== exp) begin
          failures++; $display("FAIL sweep%0d_lock%0d: got %h want %h", int'(p), k, tup(0), exp);
        end
      end
      old = p;
    end
  endtask

  task automatic test_odd_period;
    bit ok;
    int tries;
    logic [7:0] old = 8'd16, p;
    logic [20:0] exp;
    for (int i = 0; i < 2; i++) begin
      p = (i == 0) ? 8'd10 : 8'd12;
      set_gen(int'(p), int'(p), 3);
      tries = 0;
      do begin wait_valid(0, ok); tries++; end
      while (ok && b0.oPeriod == old && tries < 20);
      exp = {p, 8'd3, 3'd0, 1'b0, 1'b0};
      checks++;
      if (tup(0) !== exp) begin
        failures++; $display("FAIL odd%0d_first: got %h want %h", int'(p), tup(0), exp);
      end
      for (int k = 1; k <= 4; k++) begin
        wait_valid(0, ok);
        exp = {p, 8'd3, 3'd0, (k == 4), 1'b0};
        checks++;
        if (tup(0) !== exp) begin
          failures++; $display("FAIL odd%0d_lock%0d: got %h want %h", int'(p), k, tup(0), exp);
        end
      end
      old = p;
    end
  endtask

  task automatic test_timeout;
    bit ok;
    int n = 0, bad = 0;
    wait_valid(0, ok);
    gen_en = 1'b0; gen_lvl = 1'b0;
    while (!b0.oTimeout && n < 400) begin @(negedge iClkIN); n++; end
    checks++;
    if (n !== 255) begin
      failures++; $display("FAIL timeout_delay: got %0d cycles want 255", n);
    end
    checks++;
    if ({tup(0), b0.oValid} !== {21'd1, 1'b0}) begin
      failures++; $display("FAIL timeout_state: got %h want %h", {tup(0), b0.oValid}, {21'd1, 1'b0});
    end
    set_gen(4, 4, 2); gen_en = 1'b1;
    n = 0;
    while (!b0.oValid && n < 1000) begin
      @(negedge iClkIN); n++;
      if (!b0.oValid && !b0.oTimeout) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL timeout_hold: oTimeout low %0d cycles before oValid, want 0", bad);
    end
    checks++;
    if (tup(0) !== {8'd4, 8'd2, 3'd2, 1'b0, 1'b0}) begin
      failures++; $display("FAIL restart_first: got %h want %h", tup(0), {8'd4, 8'd2, 3'd2, 1'b0, 1'b0});
    end
  endtask

  task automatic test_max_period;
    bit ok;
    int tries = 0, n = 0, nv = 0;
    set_gen(255, 255, 100);
    do begin wait_valid(0, ok); tries++; end
    while (ok && b0.oPeriod == 8'd4 && tries < 20);
    for (int k = 1; k <= 2; k++) begin
      if (k == 2) wait_valid(0, ok);
      checks++;
      if (tup(0) !== {8'd255, 8'd100, 3'd0, 1'b0, 1'b0}) begin
        failures++; $display("FAIL max255_%0d: got %h want %h", k, tup(0), {8'd255, 8'd100, 3'd0, 1'b0, 1'b0});
      end
    end
    set_gen(256, 256, 100);
    while (!b0.oTimeout && n < 800) begin @(negedge iClkIN); n++; end
    checks++;
    if (b0.oTimeout !== 1'b1) begin
      failures++; $display("FAIL over_max_timeout: got %b want 1", b0.oTimeout);
    end
    repeat (600) begin @(negedge iClkIN); if (b0.oValid) nv++; end
    checks++;
    if (nv !== 0 || tup(0) !== 21'd1) begin
      failures++; $display("FAIL over_max_hold: valids %0d state %h want 0 and %h", nv, tup(0), 21'd1);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int tries = 0, n = 0, bad = 0;
    set_gen(4, 4, 2);
    do begin wait_valid(0, ok); tries++; end
    while (ok && !b0.oLocked && tries < 20);
    checks++;
    if (tup(0) !== {8'd4, 8'd2, 3'd2, 1'b1, 1'b0}) begin
      failures++; $display("FAIL pre_reset_lock: got %h want %h", tup(0), {8'd4, 8'd2, 3'd2, 1'b1, 1'b0});
    end
    @(posedge iClkIN); #3 iRst = 1'b1;
    #1;
    checks++;
    if ({tup(0), b0.oValid} !== 22'd0) begin
      failures++; $display("FAIL async_reset: got %h want 0", {tup(0), b0.oValid});
    end
    #4 iRst = 1'b0;
    while (!b0.oValid && n < 100) begin
      @(negedge iClkIN); n++;
      if (!b0.oValid && tup(0) !== 21'd0) bad++;
    end
    checks++;
    if (bad !== 0 || n < 5) begin
      failures++; $display("FAIL post_reset_wait: %0d bad cycles, valid after %0d cycles, want 0 and >=5", bad, n);
    end
    checks++;
    if (tup(0) !== {8'd4, 8'd2, 3'd2, 1'b0, 1'b0}) begin
      failures++; $display("FAIL post_reset_first: got %h want %h", tup(0), {8'd4, 8'd2, 3'd2, 1'b0, 1'b0});
    end
  endtask

  task automatic test_tol;
    bit ok;
    int tries = 0;
    gen_en = 1'b0; gen_lvl = 1'b0; iRst = 1'b1;
    set_gen(6, 7, 3);
    repeat (3) @(negedge iClkIN);
    iRst = 1'b0; gen_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      wait_valid(1, ok);
      checks++;
      if (!(b1.oPeriod == 8'd6 || b1.oPeriod == 8'd7) || b1.oHigh !== 8'd3 ||
          b1.oLocked !== (k >= 5)) begin
        failures++; $display("FAIL tol_meas%0d: got %h want period 6/7 high 3 locked %0d", k, tup(1), (k >= 5));
      end
    end
    checks++;
    if (b0.oLocked !== 1'b0) begin
      failures++; $display("FAIL tol0_nolock: got %b want 0", b0.oLocked);
    end
    set_gen(9, 9, 3);
    do begin wait_valid(1, ok); tries++; end
    while (ok && b1.oPeriod != 8'd9 && tries < 10);
    checks++;
    if (tup(1) !== {8'd9, 8'd3, 3'd0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL tol_break: got %h want %h", tup(1), {8'd9, 8'd3, 3'd0, 1'b0, 1'b0});
    end
  endtask

  initial begin
    test_reset;
    test_div2;
    test_sweep;
    test_odd_period;
    test_timeout;
    test_max_period;
    test_reset_mid;
    test_tol;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
